// File: rtl/half_subtractor_pkg.sv
// Shared definitions for the registered lane-parallel half subtractor.
// Optional borrow statistics are enabled by HALF_SUBTRACTOR_DF_STATS_EN.
package half_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    typedef struct packed {
        logic diff;
        logic borrow;
    } lane_result_t;

endpackage

// File: rtl/half_subtractor_df_if.sv
// Operand/result bundle for half_subtractor_df; borrow_cnt exists only when
// HALF_SUBTRACTOR_DF_STATS_EN is defined.
interface half_subtractor_df_if
    import half_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [WIDTH-1:0] Diff;
    logic [WIDTH-1:0] Borrow;
    logic             any_borrow;
`ifdef HALF_SUBTRACTOR_DF_STATS_EN
    logic [CNT_W-1:0] borrow_cnt;

    modport master (
        output in_valid, A, B,
        input  out_valid, Diff, Borrow, any_borrow, borrow_cnt
    );

    modport slave (
        input  in_valid, A, B,
        output out_valid, Diff, Borrow, any_borrow, borrow_cnt
    );
`else
    modport master (
        output in_valid, A, B,
        input  out_valid, Diff, Borrow, any_borrow
    );

    modport slave (
        input  in_valid, A, B,
        output out_valid, Diff, Borrow, any_borrow
    );
`endif

endinterface

// File: rtl/half_subtractor_df_cell.sv
// Combinational single-bit half subtractor cell: diff = a ^ b, borrow = ~a & b.
module half_subtractor_cell
    import half_subtractor_pkg::*;
(
    input  logic         a,
    input  logic         b,
    output lane_result_t result
);

    assign result.diff   = a ^ b;
    assign result.borrow = ~a & b;

endmodule

// File: rtl/half_subtractor_df.sv
// Registered lane-parallel half subtractor with valid flag and borrow OR-reduction.
// Define HALF_SUBTRACTOR_DF_STATS_EN to add the saturating borrow event counter.
module half_subtractor_df
    import half_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
)(
    input logic              clk,
    input logic              rst,
    half_subtractor_df_if.slave bus
);

    lane_result_t [WIDTH-1:0] lane_res;
    logic [WIDTH-1:0]         next_diff;
    logic [WIDTH-1:0]         next_borrow;
    logic                     next_any;

    logic                     valid_q;
    logic [WIDTH-1:0]         diff_q;
    logic [WIDTH-1:0]         borrow_q;
    logic                     any_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_subtractor_cell u_cell (
            .a      (bus.A[i]),
            .b      (bus.B[i]),
            .result (lane_res[i])
        );
        assign next_diff[i]   = lane_res[i].diff;
        assign next_borrow[i] = lane_res[i].borrow;
    end

    assign next_any = |next_borrow;

    // Results hold through idle cycles; only the valid flag follows in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= '0;
            any_q    <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                diff_q   <= next_diff;
                borrow_q <= next_borrow;
                any_q    <= next_any;
            end
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.Diff       = diff_q;
    assign bus.Borrow     = borrow_q;
    assign bus.any_borrow = any_q;

`ifdef HALF_SUBTRACTOR_DF_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts accepted operands with any borrowing lane, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.in_valid && next_any && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_subtractor_df.sv
// Self-checking bench: a WIDTH=1 and a WIDTH=4 instance against an arithmetic reference model.
module tb_half_subtractor_df;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    int w_of [2] = '{1, 4};
    int m_valid [2];
    int m_diff [2];
    int m_borrow [2];
    int m_any [2];
    int m_cnt [2];

    half_subtractor_df_if #(.WIDTH(1), .CNT_W(CNT_W)) bus1 ();
    half_subtractor_df_if #(.WIDTH(4), .CNT_W(CNT_W)) bus4 ();

    half_subtractor_df #(.WIDTH(1), .CNT_W(CNT_W)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    half_subtractor_df #(.WIDTH(4), .CNT_W(CNT_W)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Lane difference is (a - b) mod 2; a lane borrows when a < b.
    function automatic int ref_diff(int a, int b, int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            int ai = (a >> i) & 1;
            int bi = (b >> i) & 1;
            if (((ai - bi + 2) % 2) != 0) r |= (1 << i);
        end
        return r;
    endfunction

    function automatic int ref_borrow(int a, int b, int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            int ai = (a >> i) & 1;
            int bi = (b >> i) & 1;
            if (ai < bi) r |= (1 << i);
        end
        return r;
    endfunction

    task automatic model_edge(input int k, input int v, input int a, input int b);
        m_valid[k] = v;
        if (v != 0) begin
            m_diff[k]   = ref_diff(a, b, w_of[k]);
            m_borrow[k] = ref_borrow(a, b, w_of[k]);
            m_any[k]    = (m_borrow[k] != 0) ? 1 : 0;
            if (m_any[k] != 0 && m_cnt[k] < CNT_MAX) m_cnt[k]++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k]  = 0;
            m_diff[k]   = 0;
            m_borrow[k] = 0;
            m_any[k]    = 0;
            m_cnt[k]    = 0;
        end
    endtask

    task automatic check_all(input string phase);
        check_output({phase, " w1 out_valid"}, 32'(bus1.out_valid), 32'(m_valid[0]));
        check_output({phase, " w1 Diff"}, 32'(bus1.Diff), 32'(m_diff[0]));
        check_output({phase, " w1 Borrow"}, 32'(bus1.Borrow), 32'(m_borrow[0]));
        check_output({phase, " w1 any_borrow"}, 32'(bus1.any_borrow), 32'(m_any[0]));
        check_output({phase, " w4 out_valid"}, 32'(bus4.out_valid), 32'(m_valid[1]));
        check_output({phase, " w4 Diff"}, 32'(bus4.Diff), 32'(m_diff[1]));
        check_output({phase, " w4 Borrow"}, 32'(bus4.Borrow), 32'(m_borrow[1]));
        check_output({phase, " w4 any_borrow"}, 32'(bus4.any_borrow), 32'(m_any[1]));
`ifdef HALF_SUBTRACTOR_DF_STATS_EN
        check_output({phase, " w1 borrow_cnt"}, 32'(bus1.borrow_cnt), 32'(m_cnt[0]));
        check_output({phase, " w4 borrow_cnt"}, 32'(bus4.borrow_cnt), 32'(m_cnt[1]));
`endif
    endtask

    // Drive both instances, clock once, then check one time unit after the edge.
    task automatic apply_stimulus(input string phase, input int v1, input int a1, input int b1,
                                  input int v4, input int a4, input int b4);
        bus1.in_valid = 1'(v1);
        bus1.A        = 1'(a1);
        bus1.B        = 1'(b1);
        bus4.in_valid = 1'(v4);
        bus4.A        = 4'(a4);
        bus4.B        = 4'(b4);
        @(posedge clk);
        model_edge(0, v1, a1, b1);
        model_edge(1, v4, a4, b4);
        #1;
        check_all(phase);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic do_reset(input string phase);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(phase);
        #2;
        rst = 1'b0;
    endtask

    int ex_a [4] = '{0, 0, 1, 1};
    int ex_b [4] = '{0, 1, 0, 1};

    initial begin
        bus1.in_valid = 1'b0;
        bus1.A        = '0;
        bus1.B        = '0;
        bus4.in_valid = 1'b0;
        bus4.A        = '0;
        bus4.B        = '0;
        do_reset("power-on reset");

        for (int i = 0; i < 4; i++) begin
            apply_stimulus("exhaustive", 1, ex_a[i], ex_b[i],
                           1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        apply_stimulus("pre-reset borrow", 1, 0, 1, 1, 4'b0000, 4'b1111);
        do_reset("mid-cycle reset");
        apply_stimulus("post-reset idle", 0, 1, 0, 0, 4'b1010, 4'b0101);
        apply_stimulus("post-reset first", 1, 1, 1, 1, 4'b1100, 4'b1010);

        apply_stimulus("hold load", 1, 1, 0, 1, 4'b1001, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("hold idle", 0, 0, 1, 0, 4'b0000, 4'b1111);
        end

        apply_stimulus("lanes mixed", 1, 0, 0, 1, 4'b0101, 4'b0011);
        apply_stimulus("lanes no borrow", 1, 1, 1, 1, 4'b1111, 4'b0000);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus("stats saturate", 1, 0, 1, 1, 4'b0000, 4'b0001);
        end
        do_reset("stats reset");
        apply_stimulus("stats idle borrow", 0, 0, 1, 0, 4'b0000, 4'b1111);
        apply_stimulus("stats one borrow", 1, 0, 1, 1, 4'b0010, 4'b0110);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus("random", int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
